// File: rtl/bios_wdt_timer.sv
// bios_wdt_timer: seconds-based BIOS watchdog driven by the toggle-per-command
// strobes of the WDT write decoder, with warning, sticky expiry and reset-request pulse.
module bios_wdt_timer #(
    parameter int         PRESCALE    = 32768,
    parameter logic [7:0] TIMEOUT_SEC = 8'd120,
    parameter logic [7:0] WARN_SEC    = 8'd10,
    parameter int         RST_CYCLES  = 32
) (
    input  logic       MainResetN,
    input  logic       CLK32768,
    input  logic [4:0] bCPUWrWdtRegSig,
    output logic       WdtActive,
    output logic       WdtWarn,
    output logic       WdtExpired,
    output logic       WdtRstReqN,
    output logic [7:0] WdtSecRemain,
    output logic [3:0] WdtErrCnt
);
    localparam int PW = $clog2(PRESCALE);
    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam logic [PW-1:0] PRESCALE_MAX = PW'(PRESCALE - 1);
    localparam logic [RW-1:0] PULSE_LAST   = RW'(RST_CYCLES - 1);

    typedef enum logic [1:0] {DISABLED, ARMED, WARN, EXPIRED} state_t;

    state_t        state, state_n;
    logic [4:0]    sync_sig, prev_sig, evt;
    logic          unlock, unlock_n;
    logic [PW-1:0] presc, presc_n;
    logic [7:0]    sec_cnt, sec_n, sec_dec;
    logic [RW-1:0] pulse_cnt, pulse_n;
    logic          rst_req_n, rst_req_n_n;
    logic          expired, expired_n;
    logic [3:0]    err_cnt, err_n;
    logic [4:0]    err_sum;
    logic          counting, tick, cmd_dis, cmd_load, expire;

    assign evt      = sync_sig ^ prev_sig;
    assign counting = state == ARMED || state == WARN;
    assign tick     = counting && presc == PRESCALE_MAX;
    assign cmd_dis  = evt[2] & unlock;
    assign cmd_load = ~cmd_dis & (evt[1] | (evt[0] & counting));
    // a command in the tick cycle wins, so expiry only fires on an otherwise idle tick
    assign expire   = tick & ~cmd_dis & ~cmd_load & (sec_cnt <= 8'd1);
    assign sec_dec  = sec_cnt - 8'd1;
    assign err_sum  = {1'b0, err_cnt} + {4'b0, evt[4]} + {4'b0, evt[2] & ~unlock};

    always_comb begin
        state_n = state;
        sec_n   = sec_cnt;
        presc_n = counting ? presc + 1'b1 : '0;
        if (cmd_dis) begin
            state_n = DISABLED;
            sec_n   = '0;
            presc_n = '0;
        end else if (cmd_load) begin
            state_n = ARMED;
            sec_n   = TIMEOUT_SEC;
            presc_n = '0;
        end else if (tick) begin
            presc_n = '0;
            sec_n   = expire ? 8'd0 : sec_dec;
            state_n = expire ? EXPIRED : (sec_dec <= WARN_SEC ? WARN : state);
        end
        unlock_n    = evt[3] | (unlock & ~|evt);
        err_n       = err_sum > 5'd15 ? 4'hF : err_sum[3:0];
        expired_n   = expired | expire;
        pulse_n     = expire ? PULSE_LAST : (pulse_cnt != '0 ? pulse_cnt - 1'b1 : pulse_cnt);
        // the pulse runs to completion even if the timer is re-armed meanwhile
        rst_req_n_n = ~expire & (rst_req_n | pulse_cnt == '0);
    end

    always_ff @(posedge CLK32768 or negedge MainResetN) begin
        if (!MainResetN) begin
            sync_sig  <= '0;
            prev_sig  <= '0;
            unlock    <= 1'b0;
            state     <= DISABLED;
            presc     <= '0;
            sec_cnt   <= '0;
            pulse_cnt <= '0;
            rst_req_n <= 1'b1;
            expired   <= 1'b0;
            err_cnt   <= '0;
        end else begin
            sync_sig  <= bCPUWrWdtRegSig;
            prev_sig  <= sync_sig;
            unlock    <= unlock_n;
            state     <= state_n;
            presc     <= presc_n;
            sec_cnt   <= sec_n;
            pulse_cnt <= pulse_n;
            rst_req_n <= rst_req_n_n;
            expired   <= expired_n;
            err_cnt   <= err_n;
        end
    end

    assign WdtActive    = counting;
    assign WdtWarn      = state == WARN;
    assign WdtExpired   = expired;
    assign WdtRstReqN   = rst_req_n;
    assign WdtSecRemain = sec_cnt;
    assign WdtErrCnt    = err_cnt;
endmodule

// File: tb/tb_bios_wdt_timer.sv
// tb_bios_wdt_timer: directed vector table, hand sequences and random commands
// against an elapsed-time reference model of the BIOS watchdog.
module tb_bios_wdt_timer;
    localparam int PS = 4, TO = 5, WS = 2, RC = 3;

    logic       clk = 1'b0, rst_n = 1'b1;
    logic [4:0] sig = '0;
    logic       act, warn, expd, rstn;
    logic [7:0] sec;
    logic [3:0] errc;
    int         tests = 0, fails = 0;

    bios_wdt_timer #(.PRESCALE(PS), .TIMEOUT_SEC(8'(TO)), .WARN_SEC(8'(WS)), .RST_CYCLES(RC)) dut (
        .MainResetN(rst_n), .CLK32768(clk), .bCPUWrWdtRegSig(sig),
        .WdtActive(act), .WdtWarn(warn), .WdtExpired(expd), .WdtRstReqN(rstn),
        .WdtSecRemain(sec), .WdtErrCnt(errc));

    always #5 clk = ~clk;

    // model: mode 0 disabled, 1 counting, 2 expired; time kept as edges since load
    int         m_mode = 0, m_t = 0, m_load = 0, m_pulse = 0, m_err = 0;
    bit         m_unlock = 0, m_exp = 0;
    logic [4:0] d1 = '0, d2 = '0, m_evt;

    function automatic logic [15:0] model_out();
        int s;
        s = (m_mode == 1) ? TO - (m_t - m_load) / PS : 0;
        return {m_mode == 1, m_mode == 1 && s <= WS, m_exp, m_pulse == 0, 8'(s), 4'(m_err)};
    endfunction

    function automatic logic [15:0] dut_out();
        return {act, warn, expd, rstn, sec, errc};
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s @%0t: got %h expected %h (act,warn,exp,rstn | sec | err)", name, $time, got, want);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_mode = 0; m_t = 0; m_load = 0; m_pulse = 0; m_err = 0;
            m_unlock = 0; m_exp = 0; d1 = '0; d2 = '0;
        end else begin
            m_evt = d1 ^ d2;
            m_t++;
            if (m_pulse > 0) m_pulse--;
            m_err += int'(m_evt[4]) + int'(m_evt[2] && !m_unlock);
            if (m_err > 15) m_err = 15;
            if (m_evt[2] && m_unlock) m_mode = 0;
            else if (m_evt[1] || (m_evt[0] && m_mode == 1)) begin
                m_mode = 1;
                m_load = m_t;
            end else if (m_mode == 1 && m_t - m_load == TO * PS) begin
                m_mode = 2;
                m_exp = 1;
                m_pulse = RC;
            end
            m_unlock = m_evt[3] ? 1'b1 : (m_evt != 0 ? 1'b0 : m_unlock);
            d2 = d1;
            d1 = sig;
        end
    end

    initial forever begin
        @(negedge clk);
        check("model", dut_out(), model_out());
    end

    typedef struct {
        logic [4:0]  mask;
        int          cyc;
        logic [15:0] want;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input logic [4:0] m, input int c, input logic [3:0] f, input int s, input int e);
        tbl.push_back('{m, c, {f, 8'(s), 4'(e)}});
    endfunction

    initial begin
        int r;
        add(5'h00,  1, 4'b0001, 0, 0);
        add(5'h02,  2, 4'b1001, 5, 0);
        add(5'h00, 11, 4'b1001, 3, 0);
        add(5'h00,  1, 4'b1101, 2, 0);
        add(5'h00,  7, 4'b1101, 1, 0);
        add(5'h00,  1, 4'b0010, 0, 0);
        add(5'h00,  2, 4'b0010, 0, 0);
        add(5'h00,  1, 4'b0011, 0, 0);
        add(5'h01,  2, 4'b0011, 0, 0);
        add(5'h02,  2, 4'b1011, 5, 0);
        add(5'h00, 10, 4'b1011, 3, 0);
        add(5'h01,  2, 4'b1011, 5, 0);
        add(5'h00, 19, 4'b1111, 1, 0);
        add(5'h00,  1, 4'b0010, 0, 0);
        add(5'h02,  2, 4'b1010, 5, 0);
        add(5'h00,  1, 4'b1011, 5, 0);
        add(5'h08,  1, 4'b1011, 5, 0);
        add(5'h04,  2, 4'b0011, 0, 0);
        add(5'h02,  2, 4'b1011, 5, 0);
        add(5'h04,  2, 4'b1011, 5, 1);
        add(5'h08,  1, 4'b1011, 5, 1);
        add(5'h01,  1, 4'b1011, 4, 1);
        add(5'h04,  2, 4'b1011, 5, 2);
        add(5'h08,  1, 4'b1011, 5, 2);
        add(5'h04,  2, 4'b0011, 0, 2);
        add(5'h01,  2, 4'b0011, 0, 2);
        add(5'h03,  2, 4'b1011, 5, 2);
        add(5'h08,  1, 4'b1011, 5, 2);
        add(5'h06,  2, 4'b0011, 0, 2);

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        foreach (tbl[i]) begin
            sig ^= tbl[i].mask;
            repeat (tbl[i].cyc) @(negedge clk);
            check($sformatf("vec%0d", i), dut_out(), tbl[i].want);
        end

        // back-to-back toggles of one bit are separate events; then saturate
        for (int i = 0; i < 5; i++) begin
            sig ^= 5'h10;
            @(negedge clk);
        end
        @(negedge clk);
        check("err_consecutive", dut_out(), {4'b0011, 8'd0, 4'd7});
        for (int i = 0; i < 15; i++) begin
            sig ^= 5'h10;
            @(negedge clk);
        end
        @(negedge clk);
        check("err_saturate", dut_out(), {4'b0011, 8'd0, 4'hF});

        sig ^= 5'h02;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 40 && rstn; i++) @(negedge clk);
        check("pulse_seen", {15'd0, rstn}, 16'd0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        sig = '0;
        #1 check("rst_mid_pulse", dut_out(), {4'b0001, 8'd0, 4'd0});
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post_reset_quiet", dut_out(), {4'b0001, 8'd0, 4'd0});

        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 59);
            if (r == 0) sig ^= 5'(1 << $urandom_range(0, 4));
            else if (r == 1) sig ^= 5'($urandom);
            else if (r == 2) begin
                sig ^= 5'h08;
                @(negedge clk);
                sig ^= 5'h04;
            end else if (r == 3) sig ^= 5'h02;
            else if (r == 4) sig ^= 5'h01;
            else if (r == 5 && $urandom_range(0, 9) == 0) begin
                #2 rst_n = 1'b0;
                sig = '0;
                @(negedge clk);
                #1 rst_n = 1'b1;
            end
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
